threshold_ctrl: RTL and testbench

Frame sequencer for the hard-threshold stage between the DWT coefficient buffer and the RLE encoder. Latches a per-frame threshold and length on start, then streams exactly frame_len signed coefficients through a registered threshold datapath under valid/ready on both sides. Outputs an end-of-frame marker, a done pulse and a zero-count statistic that RLE control uses for buffer sizing.

---
 rtl/eeg_comp_pkg.sv | 13 +
 rtl/hard_thresh_core.sv | 25 ++
 rtl/threshold_ctrl.sv | 142 ++++++++++++++
 tb/tb_threshold_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_comp_pkg.sv
// Shared constants for the EEG compression datapath: default widths and the
// threshold-stage sequencer state encoding.
package eeg_comp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/hard_thresh_core.sv
// Combinational hard threshold: |x| < thr forces zero, otherwise x passes.
// zeroed flags only genuine suppressions (a nonzero input forced to zero).
module hard_thresh_core
  import eeg_comp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic        [DATA_W-2:0] thr,
  output logic signed [DATA_W-1:0] y,
  output logic                     zeroed
);

  logic [DATA_W:0] mag;
  logic            below;

  // One extra bit so the most negative code has a representable magnitude.
  always_comb begin
    mag    = x[DATA_W-1] ? ({1'b0, ~x} + (DATA_W+1)'(1)) : {1'b0, x};
    below  = mag < {2'b00, thr};
    zeroed = below && (x != '0);
    y      = below ? '0 : x;
  end

endmodule

// File: rtl/threshold_ctrl.sv
// Frame sequencer for the hard-threshold stage: streams frame_len coefficients
// through a registered threshold under valid/ready and reports a zero count.
module threshold_ctrl
  import eeg_comp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [LEN_W-1:0]  frame_len,
  input  logic        [DATA_W-2:0] thr,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic        [LEN_W-1:0]  zero_cnt
);

  logic [1:0]               state_q, state_d;
  logic [LEN_W-1:0]         remaining_q, remaining_d;
  logic [LEN_W-1:0]         zero_cnt_q, zero_cnt_d;
  logic [DATA_W-2:0]        thr_q, thr_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;

  logic signed [DATA_W-1:0] th_y;
  logic                     th_zeroed;
  logic                     in_acc;
  logic                     out_acc;

  hard_thresh_core #(.DATA_W(DATA_W)) u_core (
    .x      (in_data),
    .thr    (thr_q),
    .y      (th_y),
    .zeroed (th_zeroed)
  );

  // The output register may reload in the same cycle its current beat leaves.
  assign in_ready = (state_q == ST_RUN) && (remaining_q != '0) &&
                    (!out_valid_q || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the branches below leaves a variable unassigned (no latches).
    state_d     = state_q;
    remaining_d = remaining_q;
    zero_cnt_d  = zero_cnt_q;
    thr_d       = thr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_acc) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (in_acc) begin
      out_data_d  = th_y;
      out_valid_d = 1'b1;
      out_last_d  = (remaining_q == LEN_W'(1));
      remaining_d = remaining_q - LEN_W'(1);
      if (th_zeroed && (zero_cnt_q != '1)) begin
        zero_cnt_d = zero_cnt_q + LEN_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = frame_len;
          thr_d       = thr;
          zero_cnt_d  = '0;
          state_d     = (frame_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_acc && (remaining_q == LEN_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_acc && out_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a start seen in the same cycle.
    if (abort) begin
      state_d     = ST_IDLE;
      remaining_d = remaining_q;
      zero_cnt_d  = zero_cnt_q;
      thr_d       = thr_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      zero_cnt_q  <= '0;
      thr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      zero_cnt_q  <= zero_cnt_d;
      thr_q       <= thr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign zero_cnt  = zero_cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_threshold_ctrl.sv
// Directed bench for threshold_ctrl: per-scenario tasks with inline checks
// against hand-computed expectations.
module tb_threshold_ctrl;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 10;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic        [LEN_W-1:0]  frame_len;
  logic        [DATA_W-2:0] thr;
  logic                     abort;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic        [LEN_W-1:0]  zero_cnt;

  threshold_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .thr       (thr),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .zero_cnt  (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic signed [DATA_W-1:0] in_vec[16];
  int                       in_n;
  int                       abort_cyc;
  int                       spur_cyc;
  logic signed [DATA_W-1:0] got_data[16];
  logic                     got_last[16];
  int                       got_n;
  int                       done_cnt;
  int                       done_cyc;
  int                       last_out_cyc;
  int                       stall_cnt;
  int                       stall_viol;
  int                       busy_cnt;
  int                       ov_cnt;
  logic                     abort_ok;

  task automatic load_vec(input int n, input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int a5);
    int tmp[6];
    tmp = '{a0, a1, a2, a3, a4, a5};
    in_n = n;
    for (int i = 0; i < 6; i++) in_vec[i] = 8'(tmp[i]);
    abort_cyc = -1;
    spur_cyc  = -1;
  endtask

  // Issues start, then runs max_cyc cycles of handshake, recording every beat
  // handed downstream. Inputs are driven and outputs sampled on the falling edge.
  task automatic run_frame(input int len, input int th, input logic [31:0] rdy_mask,
                           input int max_cyc);
    int                       idx;
    logic                     stall_prev;
    logic signed [DATA_W-1:0] held_d;
    logic                     held_l;
    got_n = 0; done_cnt = 0; done_cyc = -1; last_out_cyc = -1;
    stall_cnt = 0; stall_viol = 0; busy_cnt = 0; ov_cnt = 0; abort_ok = 1'b1;
    idx = 0; stall_prev = 1'b0; held_d = '0; held_l = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    frame_len = 10'(len);
    thr       = 7'(th);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      in_valid  = (idx < in_n) && (abort_cyc < 0 || cyc < abort_cyc);
      in_data   = (idx < 16) ? in_vec[idx] : '0;
      out_ready = rdy_mask[cyc];
      abort     = (cyc == abort_cyc);
      start     = (cyc == spur_cyc);
      if (cyc == spur_cyc) frame_len = 10'd7;
      #1;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1 && (busy !== 1'b0 || out_valid !== 1'b0))
        abort_ok = 1'b0;
      if (stall_prev && (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l))
        stall_viol++;
      stall_prev = 1'b0;
      if (out_valid && !out_ready) begin
        stall_cnt++;
        if (in_ready !== 1'b0) stall_viol++;
        stall_prev = 1'b1;
        held_d = out_data;
        held_l = out_last;
      end
      if (out_valid && out_ready) begin
        if (got_n < 16) begin
          got_data[got_n] = out_data;
          got_last[got_n] = out_last;
        end
        got_n++;
        last_out_cyc = cyc;
      end
      if (in_valid && in_ready) idx++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy === 1'b1) busy_cnt++;
      if (out_valid === 1'b1) ov_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 8'sd0 ||
        zero_cnt !== 10'd0) begin
      fails++;
      $display("FAIL reset: rdy=%b ov=%b last=%b busy=%b done=%b data=%0d zc=%0d, expected all 0",
               in_ready, out_valid, out_last, busy, done, out_data, zero_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int exp_d[4] = '{0, -20, 0, 127};
    int exp_l[4] = '{0, 0, 0, 1};
    load_vec(4, 5, -20, -9, 127, 0, 0);
    run_frame(4, 10, 32'hFFFF_FFFF, 8);
    tests++;
    if (got_n !== 4) begin
      fails++; $display("FAIL basic beats: got %0d, expected 4", got_n);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_data[i] !== 8'(exp_d[i]) || got_last[i] !== exp_l[i][0]) begin
        fails++;
        $display("FAIL basic beat %0d: got data=%0d last=%b, expected data=%0d last=%b",
                 i, got_data[i], got_last[i], exp_d[i], exp_l[i][0]);
      end
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== last_out_cyc + 1) begin
      fails++;
      $display("FAIL basic done: pulses=%0d at cyc %0d, expected 1 at cyc %0d",
               done_cnt, done_cyc, last_out_cyc + 1);
    end
    tests++;
    if (zero_cnt !== 10'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL basic zero_cnt/busy: got %0d/%b, expected 2/0", zero_cnt, busy);
    end
  endtask

  task automatic test_neg_limit();
    load_vec(2, -128, 126, 0, 0, 0, 0);
    run_frame(2, 127, 32'hFFFF_FFFF, 6);
    tests++;
    if (got_n !== 2 || got_data[0] !== -8'sd128 || got_data[1] !== 8'sd0 ||
        got_last[1] !== 1'b1) begin
      fails++;
      $display("FAIL neg_limit: beats=%0d d0=%0d d1=%0d last1=%b, expected 2 -128 0 1",
               got_n, got_data[0], got_data[1], got_last[1]);
    end
    tests++;
    if (zero_cnt !== 10'd1) begin
      fails++; $display("FAIL neg_limit zero_cnt: got %0d, expected 1", zero_cnt);
    end
  endtask

  task automatic test_backpressure();
    int exp_d[6] = '{0, 0, 3, -4, 0, 0};
    load_vec(6, 1, 2, 3, -4, 0, -2);
    run_frame(6, 3, 32'hFFFF_FFE3, 14);
    tests++;
    if (got_n !== 6) begin
      fails++; $display("FAIL backpressure beats: got %0d, expected 6", got_n);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (got_data[i] !== 8'(exp_d[i]) || got_last[i] !== (i == 5)) begin
        fails++;
        $display("FAIL backpressure beat %0d: got data=%0d last=%b, expected data=%0d last=%b",
                 i, got_data[i], got_last[i], exp_d[i], (i == 5));
      end
    end
    tests++;
    if (stall_cnt !== 3 || stall_viol !== 0) begin
      fails++;
      $display("FAIL backpressure stall: cycles=%0d violations=%0d, expected 3/0",
               stall_cnt, stall_viol);
    end
    tests++;
    if (zero_cnt !== 10'd3 || done_cnt !== 1) begin
      fails++;
      $display("FAIL backpressure end: zero_cnt=%0d done=%0d, expected 3/1", zero_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_len_and_busy_start();
    load_vec(0, 0, 0, 0, 0, 0, 0);
    run_frame(0, 5, 32'hFFFF_FFFF, 3);
    tests++;
    if (busy_cnt !== 1 || done_cnt !== 1 || done_cyc !== 0 || ov_cnt !== 0) begin
      fails++;
      $display("FAIL zero_len: busy=%0d done=%0d@%0d ov=%0d, expected 1 1@0 0",
               busy_cnt, done_cnt, done_cyc, ov_cnt);
    end
    load_vec(3, 40, -50, 60, 0, 0, 0);
    spur_cyc = 1;
    run_frame(3, 20, 32'hFFFF_FFFF, 8);
    tests++;
    if (got_n !== 3 || done_cnt !== 1 || got_last[2] !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start: beats=%0d done=%0d last2=%b busy=%b, expected 3 1 1 0",
               got_n, done_cnt, got_last[2], busy);
    end
  endtask

  task automatic test_abort();
    load_vec(5, 3, 20, -4, 30, 1, 0);
    abort_cyc = 2;
    run_frame(5, 10, 32'hFFFF_FFFF, 6);
    tests++;
    if (got_n !== 2 || done_cnt !== 0 || abort_ok !== 1'b1) begin
      fails++;
      $display("FAIL abort: beats=%0d done=%0d idle_next=%b, expected 2 0 1",
               got_n, done_cnt, abort_ok);
    end
    tests++;
    if (zero_cnt !== 10'd1) begin
      fails++; $display("FAIL abort zero_cnt: got %0d, expected 1", zero_cnt);
    end
    load_vec(2, -7, -8, 0, 0, 0, 0);
    run_frame(2, 10, 32'hFFFF_FFFF, 6);
    tests++;
    if (got_n !== 2 || done_cnt !== 1 || zero_cnt !== 10'd2) begin
      fails++;
      $display("FAIL post_abort: beats=%0d done=%0d zero_cnt=%0d, expected 2 1 2",
               got_n, done_cnt, zero_cnt);
    end
  endtask

  task automatic test_async_reset();
    load_vec(4, 5, -20, -9, 127, 0, 0);
    run_frame(4, 10, 32'hFFFF_FFFF, 2);
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || zero_cnt !== 10'd1) begin
      fails++;
      $display("FAIL async pre: ov=%b busy=%b zc=%0d, expected 1 1 1", out_valid, busy, zero_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 8'sd0 ||
        zero_cnt !== 10'd0) begin
      fails++;
      $display("FAIL async reset: rdy=%b ov=%b last=%b busy=%b done=%b data=%0d zc=%0d, expected all 0",
               in_ready, out_valid, out_last, busy, done, out_data, zero_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_vec(1, 0, 0, 0, 0, 0, 0);
    run_frame(1, 1, 32'hFFFF_FFFF, 5);
    tests++;
    if (got_n !== 1 || got_data[0] !== 8'sd0 || got_last[0] !== 1'b1 ||
        zero_cnt !== 10'd0 || done_cnt !== 1) begin
      fails++;
      $display("FAIL async post: beats=%0d d0=%0d last=%b zc=%0d done=%0d, expected 1 0 1 0 1",
               got_n, got_data[0], got_last[0], zero_cnt, done_cnt);
    end
  endtask

  initial begin
    start = 1'b0; frame_len = '0; thr = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_n = 0; abort_cyc = -1; spur_cyc = -1;
    test_reset();
    test_basic();
    test_neg_limit();
    test_backpressure();
    test_zero_len_and_busy_start();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
